hex_bcd_display: RTL and testbench

- Memory-mapped display sink for the CPU's I/O output register. It is the write/output counterpart of the switch input path.
- When the CPU writes a 32-bit value, the block renders it on the eight active-low seven-segment digits HEX7..HEX0, in either hexadecimal or decimal.
- Decimal mode uses a sequential double-dabble binary-to-BCD converter, one bit per cycle.
- Sits between the CPU I/O write port and the top-level HEX pins.

---
 rtl/hex_bcd_display.sv | 181 ++++++++++++++++++
 tb/tb_hex_bcd_display.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hex_bcd_display.sv
`default_nettype none
// hex_bcd_display -- renders a CPU-written word on eight active-low 7-segment digits,
// as hex nibbles or as decimal via a bit-serial double-dabble converter.  Rev 1.0
module hex_bcd_display #(
  parameter int DATA_W   = 32,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              dec_mode,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5,
  output logic [6:0]        HEX6,
  output logic [6:0]        HEX7
);

  localparam int BCD_N = (DATA_W * 121 + 399) / 400;
  localparam int DIG_N = (BCD_N > 8) ? BCD_N : 8;
  localparam int DIG_W = 4 * DIG_N;
  localparam int PAD_W = (DATA_W > 32) ? DATA_W : 32;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [7:0][6:0] HEX_RST = {{7{BLANK_LZ ? SEG_BLANK : SEG_ZERO}}, SEG_ZERO};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  bin_q, bin_d;
  logic [4*BCD_N-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dec_q, dec_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic [7:0][6:0]    hex_q, hex_d;

  logic [4*BCD_N-1:0] bcd_adj;
  logic [PAD_W-1:0]   bin_pad;
  logic [DIG_W-1:0]   digits;
  logic [7:0][6:0]    img;
  logic               img_ovf;
  logic               seen_nz;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Double-dabble correction applied before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign bin_pad = PAD_W'(bin_q);

  // Digits above the eight shown still count as "higher" for blanking and flag overflow.
  always_comb begin
    digits  = dec_q ? DIG_W'(bcd_q) : DIG_W'(bin_pad[31:0]);
    img     = '0;
    img_ovf = 1'b0;
    seen_nz = 1'b0;
    for (int i = DIG_N - 1; i >= 8; i--) begin
      if (digits[4*i +: 4] != 4'd0) begin
        seen_nz = 1'b1;
        img_ovf = 1'b1;
      end
    end
    for (int i = 7; i >= 0; i--) begin
      seen_nz = seen_nz | (digits[4*i +: 4] != 4'd0);
      if (BLANK_LZ && (i != 0) && !seen_nz) begin
        img[i] = SEG_BLANK;
      end else begin
        img[i] = seg7(digits[4*i +: 4]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    hex_d   = hex_q;
    ovf_d   = ovf_q;
    if (wr_en) begin
      bin_d   = wr_data;
      dec_d   = dec_mode;
      bcd_d   = '0;
      cnt_d   = CNT_W'(DATA_W);
      state_d = dec_mode ? SHIFT : LATCH;
    end else begin
      case (state_q)
        SHIFT: begin
          {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
          cnt_d          = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = LATCH;
          end
        end
        LATCH: begin
          hex_d   = img;
          ovf_d   = img_ovf;
          state_d = IDLE;
        end
        default: ;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      hex_q   <= HEX_RST;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      hex_q   <= hex_d;
    end
  end

  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign HEX0     = hex_q[0];
  assign HEX1     = hex_q[1];
  assign HEX2     = hex_q[2];
  assign HEX3     = hex_q[3];
  assign HEX4     = hex_q[4];
  assign HEX5     = hex_q[5];
  assign HEX6     = hex_q[6];
  assign HEX7     = hex_q[7];

endmodule
`default_nettype wire

// File: tb/tb_hex_bcd_display.sv
`default_nettype none
// tb_hex_bcd_display -- directed and random writes checked against an arithmetic
// model of the display image, busy duration and hold-until-latch behaviour.
module tb_hex_bcd_display;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        dec_mode;
  logic        busy;
  logic        overflow;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

  int n_checks = 0;
  int n_errors = 0;

  logic [55:0] prev_img;
  logic [55:0] rst_img;
  logic [55:0] hex_bus;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  hex_bcd_display #(.DATA_W(32), .BLANK_LZ(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .dec_mode (dec_mode),
    .busy     (busy),
    .overflow (overflow),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .HEX6     (HEX6),
    .HEX7     (HEX7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign hex_bus = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference image: digit i of the value in base 10 or 16, blank when value < base^i.
  function automatic logic [55:0] model_img(input logic [31:0] v, input bit dec);
    logic [55:0]     im;
    longint unsigned x;
    longint unsigned base;
    longint unsigned p;
    longint unsigned q;
    im   = '0;
    x    = longint'(v);
    base = dec ? 10 : 16;
    p    = 1;
    for (int i = 0; i < 8; i++) begin
      q = x / p;
      if (i > 0 && q == 0) im[7*i +: 7] = 7'h7F;
      else                 im[7*i +: 7] = seg_tab[q % base];
      p = p * base;
    end
    return im;
  endfunction

  function automatic bit model_ovf(input logic [31:0] v, input bit dec);
    return dec && (longint'(v) > 64'd99999999);
  endfunction

  // Called at a negedge; write is taken at the following posedge.
  task automatic pulse_write(input logic [31:0] d, input bit dm);
    wr_en    = 1'b1;
    wr_data  = d;
    dec_mode = dm;
    @(negedge clk);
    wr_en    = 1'b0;
    wr_data  = $urandom;
    dec_mode = $urandom_range(0, 1);
  endtask

  task automatic wait_done(input string tag, input logic [31:0] v, input bit dec);
    int         cycles;
    bit         hold_ok;
    logic [55:0] exp_img;
    cycles  = 0;
    hold_ok = 1'b1;
    while (busy && cycles < 100) begin
      if (hex_bus !== prev_img) hold_ok = 1'b0;
      cycles++;
      @(negedge clk);
    end
    exp_img = model_img(v, dec);
    check({tag, "_busy_len"}, 64'(cycles), dec ? 64'd33 : 64'd1);
    check({tag, "_hold"}, 64'(hold_ok), 64'd1);
    check({tag, "_hex"}, 64'(hex_bus), 64'(exp_img));
    check({tag, "_ovf"}, 64'(overflow), 64'(model_ovf(v, dec)));
    prev_img = exp_img;
  endtask

  task automatic write_and_check(input string tag, input logic [31:0] v, input bit dec);
    pulse_write(v, dec);
    wait_done(tag, v, dec);
  endtask

  initial begin
    bit          ok;
    logic [31:0] rv;
    bit          rd;

    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    dec_mode = 1'b0;
    rst_img  = {{7{7'h7F}}, 7'b1000000};
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_hex", 64'(hex_bus), 64'(rst_img));
    prev_img = rst_img;
    rst = 1'b0;
    @(negedge clk);

    write_and_check("dec123456", 32'd123456, 1'b1);
    write_and_check("hexDEADBEEF", 32'hDEADBEEF, 1'b0);
    write_and_check("decFFFFFFFF", 32'hFFFFFFFF, 1'b1);
    write_and_check("dec0", 32'd0, 1'b1);
    write_and_check("dec99999999", 32'd99999999, 1'b1);
    write_and_check("dec100000000", 32'd100000000, 1'b1);
    write_and_check("hex1", 32'h1, 1'b0);
    write_and_check("hex0", 32'h0, 1'b0);

    // Second write ten cycles into a conversion restarts it without a busy gap.
    pulse_write(32'd111, 1'b1);
    ok = 1'b1;
    repeat (9) begin
      if (!busy || hex_bus !== prev_img) ok = 1'b0;
      @(negedge clk);
    end
    check("overlap_mid", 64'(ok), 64'd1);
    pulse_write(32'd42, 1'b1);
    wait_done("overlap42", 32'd42, 1'b1);

    // Reset during SHIFT aborts the conversion and nothing is latched afterwards.
    write_and_check("pre_abort", 32'hCAFE, 1'b0);
    pulse_write(32'd999, 1'b1);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ovf", 64'(overflow), 64'd0);
    check("abort_hex", 64'(hex_bus), 64'(rst_img));
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy || hex_bus !== rst_img) ok = 1'b0;
    end
    check("abort_quiet", 64'(ok), 64'd1);
    prev_img = rst_img;
    write_and_check("after_abort_hex0", 32'h0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      rv = $urandom >> $urandom_range(0, 31);
      rd = $urandom_range(0, 1);
      write_and_check("rand", rv, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
